// File: rtl/data_axi_bridge_pkg.sv
// data_axi_bridge_pkg
// Shared types and constants for the SRAM-like to AXI data bridge:
//   state_t          - bridge FSM states
//   SIZE_*           - data_size codes from the memory stage
//   CACHE_*          - AXI cache field values for uncached / write-back
//   normSize()       - folds the reserved size code 2'b11 onto word

package data_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [3:0] CACHE_UNCACHED = 4'b0000;
    localparam logic [3:0] CACHE_WB       = 4'b1111;

    // Size code 2'b11 has no AXI meaning here, so it is issued as a word.
    function automatic logic [1:0] normSize(input logic [1:0] size);
        return (size == 2'b11) ? SIZE_WORD : size;
    endfunction

endpackage

// File: rtl/data_axi_bridge.sv
// data_axi_bridge
// Turns the memory stage's req / addr_ok / data_ok data port into single-beat
// AXI reads and writes. One transaction is outstanding at a time.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   data_req/wr/size/addr/wdata/uncached - request from memory stage
//   data_addr_ok             - request accepted (high only in IDLE)
//   data_data_ok, data_rdata - one-cycle completion pulse and load data
//   axi_addr/size/cache      - latched address fields shared by AR and AW
//   arvalid/arready, rdata/rvalid/rready        - AXI read channels
//   awvalid/awready, wdata/wstrb/wvalid/wready,
//   bvalid/bready                                - AXI write channels

module data_axi_bridge
    import data_axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_uncached,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] axi_addr,
    output logic [2:0]  axi_size,
    output logic [3:0]  axi_cache,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic [3:0]  r_cache;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;
    logic        r_dataOk;
    logic        r_awDone;
    logic        r_wDone;
    logic        w_accept;
    logic        w_awFinish;
    logic        w_wFinish;

    // Byte lanes for a store; the shift drops lanes past bit 3 for a
    // misaligned half, which the memory stage never issues.
    function automatic logic [3:0] calcWstrb(input logic [1:0] size, input logic [1:0] offs);
        case (size)
            SIZE_BYTE: return 4'b0001 << offs;
            SIZE_HALF: return 4'b0011 << offs;
            default:   return 4'b1111;
        endcase
    endfunction

    assign w_accept   = (r_state == IDLE) && data_req;
    assign w_awFinish = r_awDone || awready;
    assign w_wFinish  = r_wDone  || wready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A write leaves WR_REQ only once both AW and W have
    // handshaken, whether together or in either order.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (data_req) w_nextState = data_wr ? WR_REQ : RD_ADDR;
            RD_ADDR: if (arready) w_nextState = RD_DATA;
            RD_DATA: if (rvalid) w_nextState = IDLE;
            WR_REQ:  if (w_awFinish && w_wFinish) w_nextState = WR_RESP;
            WR_RESP: if (bvalid) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Output logic. Valids drop per channel once that channel has handshaken.
    always_comb begin
        data_addr_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        case (r_state)
            IDLE:    data_addr_ok = 1'b1;
            RD_ADDR: arvalid = 1'b1;
            RD_DATA: rready = 1'b1;
            WR_REQ: begin
                awvalid = !r_awDone;
                wvalid  = !r_wDone;
            end
            WR_RESP: bready = 1'b1;
            default: data_addr_ok = 1'b0;
        endcase
    end

    // Request capture. Everything the AXI side needs is frozen here so the
    // address, data and strobe stay stable while any valid is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_size  <= 2'b00;
            r_cache <= 4'h0;
            r_wstrb <= 4'h0;
        end else if (w_accept) begin
            r_addr  <= data_addr;
            r_wdata <= data_wdata;
            r_size  <= normSize(data_size);
            r_cache <= data_uncached ? CACHE_UNCACHED : CACHE_WB;
            r_wstrb <= calcWstrb(data_size, data_addr[1:0]);
        end
    end

    // Per-channel completion flags for the write address and data channels,
    // cleared whenever the FSM is outside WR_REQ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_awDone <= 1'b0;
            r_wDone  <= 1'b0;
        end else if (r_state == WR_REQ) begin
            if (awready) r_awDone <= 1'b1;
            if (wready)  r_wDone  <= 1'b1;
        end else begin
            r_awDone <= 1'b0;
            r_wDone  <= 1'b0;
        end
    end

    // Completion: load data and the data_ok pulse both appear the cycle after
    // the R or B handshake, when the FSM is already back in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata  <= 32'h0;
            r_dataOk <= 1'b0;
        end else begin
            if (r_state == RD_DATA && rvalid) r_rdata <= rdata;
            r_dataOk <= (r_state == RD_DATA && rvalid) || (r_state == WR_RESP && bvalid);
        end
    end

    assign data_rdata   = r_rdata;
    assign data_data_ok = r_dataOk;
    assign axi_addr     = r_addr;
    assign axi_size     = {1'b0, r_size};
    assign axi_cache    = r_cache;
    assign wdata        = r_wdata;
    assign wstrb        = r_wstrb;

endmodule

// File: tb/tb_data_axi_bridge.sv
// tb_data_axi_bridge
// Directed, self-checking bench for data_axi_bridge. Each scenario task
// drives one transaction cycle by cycle and compares outputs against
// hand-computed values. Inputs change and outputs are sampled 1 ns after
// the rising edge.

module tb_data_axi_bridge;

    logic        clk;
    logic        rst;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_uncached;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] axi_addr;
    logic [2:0]  axi_size;
    logic [3:0]  axi_cache;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int compared   = 0;
    int mismatched = 0;

    data_axi_bridge dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_uncached(data_uncached),
        .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .axi_addr(axi_addr), .axi_size(axi_size), .axi_cache(axi_cache),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle's worth of acceptance.
    task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic unc);
        data_req      = 1'b1;
        data_wr       = wr;
        data_size     = size;
        data_addr     = addr;
        data_wdata    = wd;
        data_uncached = unc;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0; data_uncached = 0;
        arready = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        #12;
        compared++;
        if ({arvalid, rready, awvalid, wvalid, bready, data_data_ok} !== 6'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_handshakes: got %b want 000000",
                     {arvalid, rready, awvalid, wvalid, bready, data_data_ok});
        end
        compared++;
        if ({data_rdata, axi_addr, wdata} !== 96'h0 || axi_size !== 3'b0 || axi_cache !== 4'b0 || wstrb !== 4'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_regs: got rdata=%h addr=%h wdata=%h size=%b cache=%b wstrb=%b want all zero",
                     data_rdata, axi_addr, wdata, axi_size, axi_cache, wstrb);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        compared++;
        if (data_addr_ok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rst_addr_ok: got %b want 1", data_addr_ok);
        end
    endtask

    task automatic test_load_word();
        applyStimulus(1'b0, 2'b10, 32'h1000_0004, 32'h0, 1'b0);
        step();
        data_req = 1'b0;
        compared++;
        if (arvalid !== 1'b1 || data_addr_ok !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ld_t1: got arvalid=%b addr_ok=%b want 1/0", arvalid, data_addr_ok);
        end
        compared++;
        if (axi_addr !== 32'h1000_0004 || axi_size !== 3'b010 || axi_cache !== 4'b1111) begin
            mismatched++;
            $display("[TB] FAIL ld_fields: got %h/%b/%b want 10000004/010/1111", axi_addr, axi_size, axi_cache);
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        compared++;
        if (rready !== 1'b1 || arvalid !== 1'b0 || data_data_ok !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ld_t2: got rready=%b arvalid=%b data_ok=%b want 1/0/0", rready, arvalid, data_data_ok);
        end
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        step();
        rvalid = 1'b0;
        rdata  = 32'h0;
        compared++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'hDEAD_BEEF || data_addr_ok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ld_t3: got ok=%b rdata=%h addr_ok=%b want 1/deadbeef/1",
                     data_data_ok, data_rdata, data_addr_ok);
        end
        step();
        compared++;
        if (data_data_ok !== 1'b0 || rready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ld_t4: got ok=%b rready=%b want 0/0", data_data_ok, rready);
        end
    endtask

    task automatic test_store_byte();
        applyStimulus(1'b1, 2'b00, 32'h0000_0003, 32'h5A5A_5A5A, 1'b0);
        step();
        data_req = 1'b0;
        compared++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || wstrb !== 4'b1000 || wdata !== 32'h5A5A_5A5A) begin
            mismatched++;
            $display("[TB] FAIL sb_t1: got aw=%b w=%b wstrb=%b wdata=%h want 1/1/1000/5a5a5a5a",
                     awvalid, wvalid, wstrb, wdata);
        end
        compared++;
        if (axi_size !== 3'b000 || axi_addr !== 32'h0000_0003) begin
            mismatched++;
            $display("[TB] FAIL sb_fields: got size=%b addr=%h want 000/00000003", axi_size, axi_addr);
        end
        awready = 1'b1;
        wready  = 1'b1;
        step();
        awready = 1'b0;
        wready  = 1'b0;
        compared++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL sb_t2: got aw=%b w=%b bready=%b want 0/0/1", awvalid, wvalid, bready);
        end
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        compared++;
        if (data_data_ok !== 1'b1 || bready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL sb_t3: got ok=%b bready=%b want 1/0", data_data_ok, bready);
        end
        step();
    endtask

    task automatic test_store_half_aw_delay();
        int awCycles = 0;
        int okCount  = 0;
        applyStimulus(1'b1, 2'b01, 32'h0000_2002, 32'hBEEF_BEEF, 1'b0);
        step();
        data_req = 1'b0;
        compared++;
        if (wstrb !== 4'b1100 || axi_size !== 3'b001) begin
            mismatched++;
            $display("[TB] FAIL sh_fields: got wstrb=%b size=%b want 1100/001", wstrb, axi_size);
        end
        wready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            if (awvalid) awCycles++;
            if (data_data_ok) okCount++;
            if (c == 2) begin
                compared++;
                if (wvalid !== 1'b0 || awvalid !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL sh_w_drop: got w=%b aw=%b want 0/1", wvalid, awvalid);
                end
            end
            awready = (c == 4);
            bvalid  = (c == 5);
            step();
            wready = 1'b0;
        end
        awready = 1'b0;
        bvalid  = 1'b0;
        compared++;
        if (awCycles != 4) begin
            mismatched++;
            $display("[TB] FAIL sh_aw_len: got %0d cycles want 4", awCycles);
        end
        compared++;
        if (okCount != 1) begin
            mismatched++;
            $display("[TB] FAIL sh_ok_count: got %0d pulses want 1", okCount);
        end
    endtask

    task automatic test_uncached_stall();
        int badCycles = 0;
        applyStimulus(1'b0, 2'b11, 32'h1FC0_0010, 32'h0, 1'b1);
        step();
        data_req = 1'b0;
        compared++;
        if (axi_cache !== 4'b0000 || axi_size !== 3'b010) begin
            mismatched++;
            $display("[TB] FAIL uc_fields: got cache=%b size=%b want 0000/010", axi_cache, axi_size);
        end
        for (int c = 1; c <= 6; c++) begin
            if (arvalid !== 1'b1 || axi_addr !== 32'h1FC0_0010 || data_addr_ok !== 1'b0) badCycles++;
            arready = (c == 6);
            step();
        end
        arready = 1'b0;
        compared++;
        if (badCycles != 0) begin
            mismatched++;
            $display("[TB] FAIL uc_stable: got %0d unstable cycles want 0", badCycles);
        end
        compared++;
        if (rready !== 1'b1 || data_addr_ok !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL uc_rdata: got rready=%b addr_ok=%b want 1/0", rready, data_addr_ok);
        end
        rvalid = 1'b1;
        rdata  = 32'h1234_5678;
        step();
        rvalid = 1'b0;
        compared++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'h1234_5678) begin
            mismatched++;
            $display("[TB] FAIL uc_done: got ok=%b rdata=%h want 1/12345678", data_data_ok, data_rdata);
        end
        step();
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b0, 2'b10, 32'h0000_0100, 32'h0, 1'b0);
        step();
        data_req = 1'b0;
        arready  = 1'b1;
        step();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'hCAFE_0001;
        applyStimulus(1'b0, 2'b10, 32'h0000_0200, 32'h0, 1'b0);
        step();
        rvalid = 1'b0;
        compared++;
        if (data_data_ok !== 1'b1 || data_addr_ok !== 1'b1 || data_rdata !== 32'hCAFE_0001) begin
            mismatched++;
            $display("[TB] FAIL b2b_ok: got ok=%b addr_ok=%b rdata=%h want 1/1/cafe0001",
                     data_data_ok, data_addr_ok, data_rdata);
        end
        step();
        data_req = 1'b0;
        compared++;
        if (arvalid !== 1'b1 || axi_addr !== 32'h0000_0200 || data_data_ok !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_next: got arvalid=%b addr=%h ok=%b want 1/00000200/0",
                     arvalid, axi_addr, data_data_ok);
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'hCAFE_0002;
        step();
        rvalid = 1'b0;
        compared++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'hCAFE_0002) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: got ok=%b rdata=%h want 1/cafe0002", data_data_ok, data_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int okCount = 0;
        applyStimulus(1'b0, 2'b10, 32'h0000_0300, 32'h0, 1'b0);
        step();
        data_req = 1'b0;
        arready  = 1'b1;
        step();
        arready = 1'b0;
        compared++;
        if (rready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rm_pre: got rready=%b want 1", rready);
        end
        #2 rst = 1'b0;
        #1;
        compared++;
        if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0 || data_addr_ok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rm_async: got valids=%b addr_ok=%b want 00000/1",
                     {arvalid, rready, awvalid, wvalid, bready}, data_addr_ok);
        end
        step();
        step();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (data_data_ok) okCount++;
        end
        compared++;
        if (okCount != 0 || data_addr_ok !== 1'b1 || {arvalid, rready} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL rm_after: got ok_pulses=%0d addr_ok=%b ar/r=%b want 0/1/00",
                     okCount, data_addr_ok, {arvalid, rready});
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_store_half_aw_delay();
        test_uncached_stall();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/data_axi_bridge.md
# data_axi_bridge

Converts the memory stage's SRAM-like data request port (req / addr_ok / data_ok handshake) into single-beat AXI read and write transactions toward the interconnect. Sits directly downstream of the memory stage: accepts one request at a time, drives the AXI master channels, and returns load data or store completion as a one-cycle `data_data_ok` pulse. Fixed AXI fields (id=0, len=0, burst=INCR, lock=0, prot=0, wlast=1) are constants in the enclosing AXI wrapper, which also fans the shared address, size and cache fields out to AR and AW.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (low = reset)
- data_req  in  1  request valid from memory stage
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- data_addr  in  32  physical byte address
- data_wdata  in  32  store data, already lane-replicated by the memory stage
- data_uncached  in  1  1 = uncached access
- data_rdata  out  32  load data, valid only while data_data_ok=1
- data_addr_ok  out  1  request accepted this cycle when data_req & data_addr_ok
- data_data_ok  out  1  one-cycle completion pulse
- axi_addr  out  32  latched request address, shared by AR/AW
- axi_size  out  3  {1'b0,size}, shared by AR/AW
- axi_cache  out  4  4'b0000 if uncached, 4'b1111 if cached
- arvalid / arready  out / in  1  read address handshake
- rdata  in  32  read data
- rvalid / rready  in / out  1  read data handshake
- awvalid / awready  out / in  1  write address handshake
- wdata  out  32  latched store data
- wstrb  out  4  byte: 4'b0001<<addr[1:0]; half: 4'b0011<<addr[1:0]; word: 4'b1111
- wvalid / wready  out / in  1  write data handshake
- bvalid / bready  in / out  1  write response handshake

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- data_addr_ok = (state == IDLE), combinational; independent of data_req.
- IDLE & data_req: latch addr, wdata, size, uncached, wr; go to WR_REQ if wr, else RD_ADDR.
- RD_ADDR: arvalid=1, held until arready; then RD_DATA.
- RD_DATA: rready=1; on rvalid register rdata into data_rdata, pulse data_data_ok next cycle, go to IDLE.
- WR_REQ: awvalid and wvalid both raised on entry; each dropped independently after its own handshake (per-channel "done" flags); once both done, go to WR_RESP. AW and W may complete in the same or different cycles, in either order.
- WR_RESP: bready=1; on bvalid pulse data_data_ok next cycle, go to IDLE.
- rresp/bresp are ignored; error responses complete normally.
- AXI valids never drop before their ready (AXI rule); address/data/strobe stay stable while valid.

## Timing
- Reset values: all valids/readies 0, data_data_ok 0, data_rdata 0, axi_* 0, wdata 0, wstrb 0, state IDLE (so data_addr_ok=1 once reset is released).
- Accept at cycle t → arvalid/awvalid/wvalid high at t+1.
- Minimum load latency: accept t, arready t+1, rvalid t+2, data_data_ok t+3.
- Minimum store latency: accept t, awready & wready t+1, bvalid t+2, data_data_ok t+3.
- The data_data_ok cycle is already IDLE: a new request may be accepted in that same cycle.
- Never more than one outstanding transaction; data_addr_ok=0 in all non-IDLE states.
- Reset asserted mid-transaction: immediate return to IDLE with all valids low; the interconnect is reset by the same global reset.

## Structure
- Shared package: FSM state enum, size codes (SIZE_BYTE/HALF/WORD), cache constants (CACHE_UNCACHED=4'b0000, CACHE_WB=4'b1111).
- No sub-module; wstrb generation is a local function.

## Test plan
- Load word at 0x1000_0004, arready and rvalid immediately → axi_size=3'b010, data_data_ok at t+3, data_rdata = rdata (0xDEADBEEF).
- Store byte at 0x0000_0003 with data_wdata=0x5A5A5A5A → wstrb=4'b1000, wdata=0x5A5A5A5A, data_data_ok one cycle after bvalid.
- Store half with awready delayed 3 cycles and wready immediate → wvalid low after 1 beat, awvalid held 4 cycles, exactly one data_data_ok.
- Uncached load (data_uncached=1), arready stalled 5 cycles → axi_cache=0, arvalid and axi_addr stable throughout, data_addr_ok=0 until completion.
- Back-to-back: new data_req held high during the data_data_ok cycle → accepted in that cycle (data_addr_ok=1), next arvalid the following cycle.
- rst low during RD_DATA → all valids 0 and data_addr_ok=1 after release; no spurious data_data_ok.
